// File: rtl/parity_pkg.sv
// Shared types and helpers for the parity framing path (parity_calc / parity_frame_tx).
package parity_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    // Zero-extension leaves the XOR unchanged, so any word up to 64 bits can be passed in.
    function automatic logic calc_even_parity(input logic [63:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/parity_frame_tx_bit_timer.sv
// Bit-period timer: counts 0..BIT_CYCLES-1 and flags the terminal count.
module bit_timer
    import parity_pkg::*;
#(
    parameter int BIT_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CW-1:0] TC = CW'(BIT_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // With BIT_CYCLES=1 the count never leaves 0, so tick is high every cycle.
    assign tick = (cnt_q == TC);

    always_comb begin
        cnt_d = (clr || tick) ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/parity_frame_tx.sv
// Framed serial transmitter: start, data LSB-first, parity, stop; each bit BIT_CYCLES clocks.
// Define PARITY_FRAME_RECHECK_EN to recompute parity on accept and flag mismatches on par_err.
//
// state  | meaning
// IDLE   | line high, ready for a word
// START  | start bit (low)
// DATA   | data bits, LSB first
// PARITY | latched parity bit
// STOP   | stop bit (high), then back to IDLE with frame_done
module parity_frame_tx
    import parity_pkg::*;
#(
    parameter int WIDTH      = 10,
    parameter int BIT_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data,
    input  logic             par,
    input  logic             valid,
    output logic             ready,
    output logic             tx,
    output logic             busy,
    output logic             frame_done,
    output logic             par_err
);

    localparam int FRAME_BITS = WIDTH + 3;
    localparam int IW = $clog2(FRAME_BITS);
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    tx_state_t        state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             par_q, par_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             tick;
    logic             handshake;

    assign ready     = (state_q == ST_IDLE);
    assign handshake = valid && ready;

    // Held clear through IDLE so the first START cycle always begins at count 0.
    bit_timer #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_bit_timer (
        .clk (clk),
        .rst (rst),
        .clr (ready),
        .tick(tick)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        par_d   = par_q;
        idx_d   = idx_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (handshake) begin
                    state_d = ST_START;
                    shift_d = data;
                    par_d   = par;
                    idx_d   = '0;
                end
            end
            ST_START: begin
                if (tick) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (tick) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_PARITY;
                    end else begin
                        shift_d = shift_q >> 1;
                        idx_d   = idx_q + IW'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (tick) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (tick) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so they line up with the registered state.
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = par_d;
            default:   tx_d = 1'b1;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            par_q   <= 1'b0;
            idx_q   <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

`ifdef PARITY_FRAME_RECHECK_EN
    logic perr_q, perr_d;

    // The frame still goes out with the received parity; this only raises a sticky flag.
    always_comb begin
        perr_d = perr_q | (handshake && (calc_even_parity(64'(data)) != par));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end

    assign par_err = perr_q;
`else
    assign par_err = 1'b0;
`endif

endmodule
